// File: rtl/lzd_pkg.sv
// Shared types and defaults for the LZD normalizer / denormalizer pair.
// LZD_DENORM_ROUND_EN adds one guard bit to the datapath for half-up rounding.
package lzd_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int SHIFT_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0]  mant_t;
  typedef logic [SHIFT_W_DEF-1:0] shift_t;

`ifdef LZD_DENORM_ROUND_EN
  localparam int GUARD_W = 1;
`else
  localparam int GUARD_W = 0;
`endif

endpackage

// File: rtl/lzd_denorm_stage.sv
// One pipeline stage of the denormalizer: right shift by in_amt*GRAN into a
// registered slot with valid/ready flow control.
module lzd_denorm_stage
  import lzd_pkg::*;
#(
  parameter int EXT_W = DATA_W_DEF + GUARD_W,
  parameter int AMT_W = 2,
  parameter int GRAN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXT_W-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXT_W-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [EXT_W-1:0] data_q, data_d;

  // The slot refills whenever it is empty or its contents leave this cycle.
  always_comb begin
    in_ready = ~valid_q | out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data >> (int'(in_amt) * GRAN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/lzd_denorm.sv
// Denormalizer: out_data = in_mant >> in_shift over a coarse (x4) and a fine (x1)
// pipeline stage. Define LZD_DENORM_ROUND_EN for half-up rounding instead of truncation.
module lzd_denorm
  import lzd_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_mant,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);

  // A guard bit below the LSB catches the most significant shifted-out bit
  // for free as the word moves through both shifters.
  localparam int EXT_W    = DATA_W + GUARD_W;
  localparam int COARSE_W = SHIFT_W - 2;

  logic             accept;
  logic [EXT_W-1:0] s1_in;
  logic [1:0]       s1_fine_q, s1_fine_d;
  logic             s1_valid;
  logic [EXT_W-1:0] s1_data;
  logic             s2_in_ready;
  logic [EXT_W-1:0] s2_data;

  // Zero words and over-range shifts are flattened before the first shifter.
  always_comb begin
    accept    = in_valid & in_ready;
    s1_fine_d = accept ? in_shift[1:0] : s1_fine_q;
    if (in_zero || (int'(in_shift) >= DATA_W)) begin
      s1_in = '0;
    end else begin
      s1_in = EXT_W'(in_mant) << GUARD_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_fine_q <= '0;
    end else begin
      s1_fine_q <= s1_fine_d;
    end
  end

  lzd_denorm_stage #(
    .EXT_W (EXT_W),
    .AMT_W (COARSE_W),
    .GRAN  (4)
  ) u_coarse (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .in_amt    (in_shift[SHIFT_W-1:2]),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  lzd_denorm_stage #(
    .EXT_W (EXT_W),
    .AMT_W (2),
    .GRAN  (1)
  ) u_fine (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s1_data),
    .in_amt    (s1_fine_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

`ifdef LZD_DENORM_ROUND_EN
  // A right shift of 1+ leaves the MSB clear, so adding the guard bit cannot overflow.
  assign out_data = s2_data[EXT_W-1:1] + DATA_W'(s2_data[0]);
`else
  assign out_data = s2_data;
`endif

endmodule

// File: tb/tb_lzd_denorm.sv
// Directed-vector and stream bench for lzd_denorm (default 16-bit build,
// expectations follow LZD_DENORM_ROUND_EN when it is defined).
module tb_lzd_denorm;
  import lzd_pkg::*;

  typedef struct {
    mant_t  mant;
    shift_t shift;
    logic   zero;
    mant_t  expTrunc;
    mant_t  expRound;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  mant_t  in_mant = '0;
  shift_t in_shift = '0;
  logic   in_zero = 1'b0;
  logic   out_valid;
  logic   out_ready = 1'b0;
  mant_t  out_data;

  int     checks = 0;
  int     failures = 0;
  mant_t  expQ[$];
  logic   monStall = 1'b0;
  mant_t  monHeld = '0;
  logic   randDone = 1'b0;
  vec_t   vecs[12];

  always #5 clk = ~clk;

  lzd_denorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_shift  (in_shift),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic noteFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  function automatic mant_t refModel(input mant_t m, input shift_t s, input logic z);
    mant_t r;
    if (z) return '0;
    r = m >> s;
`ifdef LZD_DENORM_ROUND_EN
    if (s != 0) r = r + mant_t'(m[int'(s) - 1]);
`endif
    return r;
  endfunction

  // Drives one word and returns just after the edge that accepted it.
  task automatic applyStimulus(input mant_t m, input shift_t s, input logic z, input mant_t expected);
    logic rdy;
    logic got;
    in_valid = 1'b1;
    in_mant  = m;
    in_shift = s;
    in_zero  = z;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (got) expQ.push_back(expected);
    else noteFail("accept_timeout");
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
    end
    #1;
    checkOutput("drained", expQ.size(), 0);
  endtask

  // Output monitor: in-order scoreboard plus hold-stability under backpressure.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      monStall = 1'b0;
    end else begin
      if (monStall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, monHeld);
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) noteFail("unexpected_output");
        else checkOutput("stream_data", out_data, expQ.pop_front());
        monStall = 1'b0;
      end else if (out_valid) begin
        monStall = 1'b1;
        monHeld  = out_data;
      end else begin
        monStall = 1'b0;
      end
    end
  end

  initial begin
    vecs[0]  = '{16'h8000, 4'd3,  1'b0, 16'h1000, 16'h1000};
    vecs[1]  = '{16'h8003, 4'd2,  1'b0, 16'h2000, 16'h2001};
    vecs[2]  = '{16'hFFFF, 4'd5,  1'b1, 16'h0000, 16'h0000};
    vecs[3]  = '{16'h8000, 4'd15, 1'b0, 16'h0001, 16'h0001};
    vecs[4]  = '{16'hABCD, 4'd0,  1'b0, 16'hABCD, 16'hABCD};
    vecs[5]  = '{16'hFFFF, 4'd4,  1'b0, 16'h0FFF, 16'h1000};
    vecs[6]  = '{16'hC000, 4'd15, 1'b0, 16'h0001, 16'h0002};
    vecs[7]  = '{16'h9ABC, 4'd8,  1'b0, 16'h009A, 16'h009B};
    vecs[8]  = '{16'h8421, 4'd1,  1'b0, 16'h4210, 16'h4211};
    vecs[9]  = '{16'hF0F0, 4'd12, 1'b0, 16'h000F, 16'h000F};
    vecs[10] = '{16'h8001, 4'd13, 1'b0, 16'h0004, 16'h0004};
    vecs[11] = '{16'hFFFF, 4'd7,  1'b0, 16'h01FF, 16'h0200};

    // Reset state, with downstream stalled so in_ready reflects an empty pipe.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    checkOutput("rst_in_ready", in_ready, 1);

    // Directed vectors, one at a time, checking the two-stage latency.
    out_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
`ifdef LZD_DENORM_ROUND_EN
      applyStimulus(vecs[v].mant, vecs[v].shift, vecs[v].zero, vecs[v].expRound);
`else
      applyStimulus(vecs[v].mant, vecs[v].shift, vecs[v].zero, vecs[v].expTrunc);
`endif
      @(negedge clk);
      checkOutput($sformatf("lat_early_%0d", v), out_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("lat_valid_%0d", v), out_valid, 1);
      @(posedge clk);
      #1;
    end
    waitDrain();

    // Three back-to-back words against four stalled cycles.
    out_ready = 1'b0;
    applyStimulus(16'h1234, 4'd4, 1'b0, 16'h0123);
    in_valid = 1'b1;
    applyStimulus(16'hFFFF, 4'd0, 1'b0, 16'hFFFF);
    checkOutput("full_in_ready", in_ready, 0);
    fork
      applyStimulus(16'h8000, 4'd1, 1'b0, 16'h4000);
      begin
        repeat (2) begin
          @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with two words in flight must discard both.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(16'h8888, 4'd2, 1'b0, 16'h2222);
    applyStimulus(16'h9000, 4'd3, 1'b0, 16'h1200);
    rst_n = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_stale", out_valid, 0);
    end

    // Random stream with random downstream backpressure.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          mant_t  m;
          shift_t s;
          logic   z;
          m = mant_t'($urandom) | 16'h8000;
          s = shift_t'($urandom_range(0, 15));
          z = ($urandom_range(0, 7) == 0);
          applyStimulus(m, s, z, refModel(m, s, z));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzd_denorm.md
LZD_DENORM -- requirements
Module: lzd_denorm

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the mantissa and result width; legal values are multiples of 4 from 8 to 32.
REQ-002 SHALL have parameter SHIFT_W, default 4, giving the shift-count width; it equals clog2(DATA_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the upstream word.
REQ-007 SHALL have port in_mant, input, DATA_W bits: the normalized mantissa (MSB set unless in_zero).
REQ-008 SHALL have port in_shift, input, SHIFT_W bits: the leading-zero count to reinsert, as produced by the LZD tree.
REQ-009 SHALL have port in_zero, input, 1 bit: the LZD valid flag inverted; the source word was all zeros.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_data, output, DATA_W bits: the denormalized fixed-point result.

Function
REQ-013 SHALL compute out_data = in_mant >> in_shift, forcing out_data to 0 when in_zero=1 regardless of in_mant and in_shift.
REQ-014 SHALL be a 2-stage pipeline: stage 1 is the coarse shift by in_shift[SHIFT_W-1:2]*4; stage 2 is the fine shift by in_shift[1:0].
REQ-015 SHALL have a latency of exactly 2 cycles from the accept edge (in_valid & in_ready) to out_valid when out_ready is held at 1.
REQ-016 SHALL sustain a throughput of 1 word per cycle while out_ready=1.
REQ-017 SHALL transfer a word on an edge only when valid=1 and ready=1 on that interface.
REQ-018 SHALL advance stage N when stage N is empty or stage N+1 can advance.
REQ-019 SHALL drive in_ready = ~s1_valid | stage-2 advance; in_ready is combinational from out_ready, with no combinational path from in_valid.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL carry the shifted-out bits (sticky/round information) from stage 1 to stage 2.
REQ-022 SHALL produce out_data = in_mant when in_shift=0.
REQ-023 SHALL produce out_data = in_mant[DATA_W-1] when in_shift = DATA_W-1 (wrap-free; no modulo shifting).
REQ-024 SHALL treat in_shift >= DATA_W as a result of 0.
REQ-025 SHALL not overflow out_data; the result needs no saturation because a right shift of 1 or more plus rounding never exceeds 2^(DATA_W-1).
REQ-026 SHALL, on a simultaneous accept and output handshake in the same cycle, keep both transfers and lose or duplicate no word.

Reset
REQ-027 SHALL, with rst_n=0 at a rising edge, clear s1_valid, s2_valid and out_valid to 0 and set out_data to 0.
REQ-028 SHALL hold in_ready=1 after reset with the pipeline empty.
REQ-029 SHALL discard in-flight words when reset is asserted mid-operation, with no output for them after release.

Configuration
REQ-030 SHALL, with LZD_DENORM_ROUND_EN defined, round half-up: add the most significant shifted-out bit to the truncated result.
REQ-031 SHALL, with LZD_DENORM_ROUND_EN undefined, truncate, remove the rounding logic, and leave latency and handshake identical.

Structure
REQ-032 SHALL place DATA_W_DEF, SHIFT_W_DEF, mant_t and shift_t in package lzd_pkg, shared with the LZD normalizer.
REQ-033 SHALL implement each stage as an instance of sub-module lzd_denorm_stage, parameterized by shift granularity (4 or 1), holding the stage register and valid/ready logic.

Verification
REQ-034 SHALL check: in_mant=0x8000, in_shift=3, in_zero=0, out_ready=1 -> out_data=0x1000 with out_valid exactly 2 cycles after accept.
REQ-035 SHALL check: in_mant=0x8003, in_shift=2 -> out_data=0x2000 without LZD_DENORM_ROUND_EN, 0x2001 with it.
REQ-036 SHALL check: in_zero=1, in_mant=0xFFFF, in_shift=5 -> out_data=0x0000; in_mant=0x8000, in_shift=15 -> out_data=0x0001.
REQ-037 SHALL check: 3 back-to-back words with out_ready=0 for 4 cycles -> in_ready=0 once both stages are full, no word lost, and results delivered in order after out_ready=1.
REQ-038 SHALL check: rst_n=0 for 1 cycle with 2 words in flight -> out_valid=0 next cycle, in_ready=1, and no stale output.
REQ-039 SHALL check: random streams with random out_ready against the reference model mant>>shift -> every word matches, in order.
